// File: rtl/tlc_phase_arbiter.sv
// Purpose : demand-driven right-of-way arbiter for N_PHASES vehicle approaches plus a latched
//           pedestrian crossing, with min/max green, yellow and all-red clearance timing.
// Latency : lamp outputs are decoded from registered state only; an input change can affect the
//           lamps from the cycle after the edge that samples it.
// Backpressure: none. A pedestrian press is held in a latch until it is served, and a vehicle
//           request is served only if it is still asserted at the all-red decision cycle.
// Ports   : i_clk, i_rst (synchronous, active-high) ; i_req[N] per-approach detectors (level) ;
//           i_ped_req push-button (pulse or level) ; o_green/o_yellow/o_red[N] lamps ;
//           o_ped_walk WALK lamp ; o_phase last/current granted approach ; o_timer cycles in state.
module tlc_phase_arbiter #(
  parameter int N_PHASES  = 4,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 15,
  parameter int CNT_W     = 6,
  localparam int PW       = $clog2(N_PHASES)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_PHASES-1:0] i_req,
  input  logic                i_ped_req,
  output logic [N_PHASES-1:0] o_green,
  output logic [N_PHASES-1:0] o_yellow,
  output logic [N_PHASES-1:0] o_red,
  output logic                o_ped_walk,
  output logic [PW-1:0]       o_phase,
  output logic [CNT_W-1:0]    o_timer
);

  localparam logic [1:0] ST_ALL_RED  = 2'd0;
  localparam logic [1:0] ST_GREEN    = 2'd1;
  localparam logic [1:0] ST_YELLOW   = 2'd2;
  localparam logic [1:0] ST_PED_WALK = 2'd3;

  // Last-cycle timer values: a state whose exit first holds at T-1 lasts exactly T cycles.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WLK_LAST = CNT_W'(WALK_T - 1);

  logic [1:0]          state, next_state;
  logic [CNT_W-1:0]    timer;
  logic [PW-1:0]       phase, next_phase;
  logic                ped_latch;
  logic                ped_served;

  logic [N_PHASES-1:0] cur_oh;
  logic                other_demand;
  logic [PW-1:0]       rr_pick;
  logic                rr_found;
  logic                enter_walk;
  logic                enter_green;

  // One-hot of the current phase and the "someone else is waiting" term.
  always_comb begin
    cur_oh        = '0;
    cur_oh[phase] = 1'b1;
    other_demand  = ((i_req & ~cur_oh) != '0) || ped_latch;
  end

  // Round-robin pick: first requesting approach searching upward from phase+1 with wrap.
  // Offset N_PHASES comes back to the current phase, so it is picked only if alone.
  always_comb begin
    int          sum;
    logic [PW-1:0] idx;
    rr_pick  = phase;
    rr_found = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int k = 1; k <= N_PHASES; k++) begin
      sum = int'(phase) + k;
      if (sum >= N_PHASES) sum = sum - N_PHASES;
      idx = PW'(sum);
      if (!rr_found && i_req[idx]) begin
        rr_pick  = idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_phase = phase;
    case (state)
      ST_GREEN: begin
        // Max-out, or gap-out once min green is met and our own detector has dropped.
        if (other_demand &&
            ((timer >= MAX_LAST) || ((timer >= MIN_LAST) && !i_req[phase])))
          next_state = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (timer == YEL_LAST) next_state = ST_ALL_RED;
      end
      ST_PED_WALK: begin
        if (timer == WLK_LAST) next_state = ST_ALL_RED;
      end
      default: begin
        // ALL_RED decision point; rest in red while nothing is waiting.
        if (timer >= AR_LAST) begin
          // ped_served forces a vehicle green between walks unless no vehicle waits.
          if (ped_latch && (!ped_served || (i_req == '0))) begin
            next_state = ST_PED_WALK;
          end else if (i_req != '0) begin
            next_state = ST_GREEN;
            next_phase = rr_pick;
          end
        end
      end
    endcase
  end

  assign enter_walk  = (next_state == ST_PED_WALK) && (state != ST_PED_WALK);
  assign enter_green = (next_state == ST_GREEN) && (state != ST_GREEN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_ALL_RED;
      timer      <= '0;
      phase      <= PW'(N_PHASES - 1);
      ped_latch  <= 1'b0;
      ped_served <= 1'b0;
    end else begin
      state <= next_state;
      phase <= next_phase;
      if (next_state != state) timer <= '0;
      else if (timer != '1)    timer <= timer + 1'b1;

      // Clearing on walk entry wins over a press in the same cycle.
      if (enter_walk)                              ped_latch <= 1'b0;
      else if (i_ped_req && (state != ST_PED_WALK)) ped_latch <= 1'b1;

      if (enter_walk)       ped_served <= 1'b1;
      else if (enter_green) ped_served <= 1'b0;
    end
  end

  assign o_green    = (state == ST_GREEN)  ? cur_oh : '0;
  assign o_yellow   = (state == ST_YELLOW) ? cur_oh : '0;
  assign o_red      = ~(o_green | o_yellow);
  assign o_ped_walk = (state == ST_PED_WALK);
  assign o_phase    = phase;
  assign o_timer    = timer;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Purpose : directed bench for tlc_phase_arbiter with default parameters.
// Latency : outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: not applicable.
module tb_tlc_phase_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ped_req;
  logic [3:0] green, yellow, red;
  logic       ped_walk;
  logic [1:0] phase;
  logic [5:0] timer;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tlc_phase_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_ped_req  (ped_req),
    .o_green    (green),
    .o_yellow   (yellow),
    .o_red      (red),
    .o_ped_walk (ped_walk),
    .o_phase    (phase),
    .o_timer    (timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Apply reset for one edge, then release with the given request vector.
  task automatic do_reset(input logic [3:0] r);
    rst     = 1'b1;
    ped_req = 1'b0;
    tick(1);
    rst = 1'b0;
    req = r;
  endtask

  initial begin
    logic [3:0] exp_oh;
    logic       saw_yellow;
    int         red_bad;
    int         p;

    rst = 1'b1; req = 4'b0000; ped_req = 1'b0;
    tick(2);
    rst = 1'b0;

    // 1. Idle after reset: all red, timer saturates.
    chk("rst_red",    red,      4'b1111);
    chk("rst_green",  green,    4'b0000);
    chk("rst_yellow", yellow,   4'b0000);
    chk("rst_walk",   ped_walk, 1'b0);
    chk("rst_timer",  timer,    6'd0);
    chk("rst_phase",  phase,    2'd3);
    red_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (red !== 4'b1111 || green !== 4'b0000) red_bad = red_bad + 1;
    end
    chk("idle_red_cycles_bad", red_bad, 0);
    chk("idle_timer_sat",      timer,   6'd63);

    // 2. Single demand from reset: green at cycle 2, rests indefinitely.
    do_reset(4'b0001);
    tick(1);
    chk("first_green_c1", green, 4'b0000);
    tick(1);
    chk("first_green_c2", green, 4'b0001);
    chk("first_phase",    phase, 2'd0);
    chk("first_timer",    timer, 6'd0);
    saw_yellow = 1'b0;
    for (int i = 0; i < 110; i++) begin
      tick(1);
      if (yellow !== 4'b0000) saw_yellow = 1'b1;
    end
    chk("rest_no_yellow", saw_yellow, 1'b0);
    chk("rest_green",     green,      4'b0001);
    chk("rest_timer_sat", timer,      6'd63);

    // 3. Gap-out: drop req0 / raise req2 at green timer=4.
    do_reset(4'b0001);
    tick(6);
    chk("gap_timer4", timer, 6'd4);
    req = 4'b0100;
    tick(5);
    chk("gap_green_t9", green, 4'b0001);
    tick(1);
    chk("gap_yellow",   yellow, 4'b0001);
    chk("gap_red_yel",  red,    4'b1110);
    tick(3);
    chk("gap_yellow_t3", yellow, 4'b0001);
    tick(1);
    chk("gap_allred",   red,   4'b1111);
    tick(1);
    chk("gap_allred_t1", red,  4'b1111);
    tick(1);
    chk("gap_green2",   green, 4'b0100);
    chk("gap_phase2",   phase, 2'd2);

    // 4. Max-out rotation with all approaches waiting.
    do_reset(4'b1111);
    tick(2);
    chk("rot_green0", green, 4'b0001);
    p = 0;
    for (int n = 0; n < 4; n++) begin
      exp_oh = 4'b0001 << p;
      tick(39);
      chk("rot_green_t39", green, exp_oh);
      tick(1);
      chk("rot_yellow", yellow, exp_oh);
      tick(4);
      chk("rot_allred", red, 4'b1111);
      tick(2);
      p = (p + 1) % 4;
      exp_oh = 4'b0001 << p;
      chk("rot_next_green", green, exp_oh);
      chk("rot_next_phase", phase, p);
    end

    // 5. Pedestrian pulse at green timer=3; second pulse during walk ignored.
    do_reset(4'b0001);
    tick(5);
    chk("ped_timer3", timer, 6'd3);
    ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0;
    tick(35);
    chk("ped_green_t39", green, 4'b0001);
    tick(1);
    chk("ped_yellow", yellow, 4'b0001);
    tick(4);
    chk("ped_allred", red, 4'b1111);
    chk("ped_nowalk_yet", ped_walk, 1'b0);
    tick(2);
    chk("ped_walk_on",  ped_walk, 1'b1);
    chk("ped_walk_red", red,      4'b1111);
    tick(5);
    ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0;
    tick(8);
    chk("ped_walk_t14", ped_walk, 1'b1);
    tick(1);
    chk("ped_walk_off", ped_walk, 1'b0);
    chk("ped_after_red", red, 4'b1111);
    tick(2);
    chk("ped_back_green", green, 4'b0001);
    chk("ped_back_phase", phase, 2'd0);
    tick(60);
    chk("ped_second_ignored", green, 4'b0001);

    // 6. Reset mid-yellow with the ped latch set.
    do_reset(4'b0001);
    tick(2);
    ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0;
    tick(39);
    chk("rst6_yellow", yellow, 4'b0001);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rst6_red",    red,      4'b1111);
    chk("rst6_yellow_off", yellow, 4'b0000);
    chk("rst6_timer",  timer,    6'd0);
    chk("rst6_phase",  phase,    2'd3);
    rst = 1'b0;
    req = 4'b0000;
    tick(5);
    chk("rst6_latch_cleared", ped_walk, 1'b0);
    chk("rst6_still_red",     red,      4'b1111);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
